traffic_request_unit: RTL and testbench



---
 rtl/traffic_request_unit.sv | 178 +++++++++++++++++
 tb/tb_traffic_request_unit.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_request_unit.sv
// Per-approach sensor debounce, request latch, serve-clear and starvation flag for the intersection controller.
// Latency: request rises DEBOUNCE-1 edges after the first high sample edge; clear on the edge green is sampled.
// No backpressure: outputs are decoded from registered state only. Optional conflict checker: TRC_CONFLICT_EN.
module traffic_request_unit #(
    parameter int DEBOUNCE = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] sensor,
    input  logic [2:0] ns_light,
    input  logic [2:0] ew_light,
    input  logic [2:0] sw_ne_light,
    input  logic [2:0] wn_es_light,
    output logic       ns_traffic,
    output logic       ew_traffic,
    output logic       sw_ne_traffic,
    output logic       wn_es_traffic,
    output logic [3:0] starve,
    output logic       conflict
);

    localparam int DCW = $clog2(DEBOUNCE + 1);
    localparam int AW  = $clog2(MAX_WAIT + 1);

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PENDING,
        S_SERVED
    } state_t;

    state_t         state_q [4];
    state_t         state_d [4];
    logic [DCW-1:0] deb_q   [4];
    logic [DCW-1:0] deb_d   [4];
    logic [AW-1:0]  age_q   [4];
    logic [AW-1:0]  age_d   [4];

    logic [2:0] light [4];
    logic [3:0] green;

    assign light[0] = ns_light;
    assign light[1] = ew_light;
    assign light[2] = sw_ne_light;
    assign light[3] = wn_es_light;

    // Green decode per approach, shared by the FSMs and the conflict checker
    always_comb begin
        green = '0;
        for (int i = 0; i < 4; i++) begin
            green[i] = (light[i] == LIGHT_GREEN);
        end
    end

    // Next-state logic for the four independent approach FSMs
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            deb_d[i]   = deb_q[i];
            age_d[i]   = age_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (sensor[i]) begin
                        if (DEBOUNCE == 1) begin
                            state_d[i] = S_PENDING;
                            deb_d[i]   = '0;
                            age_d[i]   = '0;
                        end else begin
                            state_d[i] = S_DEBOUNCE;
                            deb_d[i]   = DCW'(1);
                        end
                    end
                end
                S_DEBOUNCE: begin
                    // Green is deliberately ignored here; clearance waits for PENDING
                    if (!sensor[i]) begin
                        state_d[i] = S_IDLE;
                        deb_d[i]   = '0;
                    end else if (deb_q[i] + DCW'(1) == DCW'(DEBOUNCE)) begin
                        state_d[i] = S_PENDING;
                        deb_d[i]   = '0;
                        age_d[i]   = '0;
                    end else begin
                        deb_d[i] = deb_q[i] + DCW'(1);
                    end
                end
                S_PENDING: begin
                    // Green wins over ageing on the same edge
                    if (green[i]) begin
                        state_d[i] = S_SERVED;
                        age_d[i]   = '0;
                    end else if (age_q[i] != AW'(MAX_WAIT)) begin
                        age_d[i] = age_q[i] + AW'(1);
                    end
                end
                S_SERVED: begin
                    // Sensor ignored until the green ends, so a waiting car re-arms afterwards
                    if (!green[i]) begin
                        state_d[i] = S_IDLE;
                        deb_d[i]   = '0;
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    deb_d[i]   = '0;
                    age_d[i]   = '0;
                end
            endcase
        end
    end

    // State and counter registers, cleared asynchronously
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= S_IDLE;
                deb_q[i]   <= '0;
                age_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                deb_q[i]   <= deb_d[i];
                age_q[i]   <= age_d[i];
            end
        end
    end

    // Requests and starve flags decode straight from registered state and age
    always_comb begin
        starve = '0;
        for (int i = 0; i < 4; i++) begin
            starve[i] = (state_q[i] == S_PENDING) && (age_q[i] == AW'(MAX_WAIT));
        end
    end

    assign ns_traffic    = (state_q[0] == S_PENDING);
    assign ew_traffic    = (state_q[1] == S_PENDING);
    assign sw_ne_traffic = (state_q[2] == S_PENDING);
    assign wn_es_traffic = (state_q[3] == S_PENDING);

`ifdef TRC_CONFLICT_EN
    logic conflict_q;
    logic conflict_d;
    logic illegal;

    // Illegal when any light is not exactly one-hot or more than one approach is green
    always_comb begin
        illegal = ((green & (green - 4'd1)) != 4'd0);
        for (int i = 0; i < 4; i++) begin
            if ((light[i] != LIGHT_RED) && (light[i] != LIGHT_YELLOW) &&
                (light[i] != LIGHT_GREEN)) begin
                illegal = 1'b1;
            end
        end
        conflict_d = conflict_q | illegal;
    end

    // Sticky conflict flag, only reset clears it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict = conflict_q;
`else
    assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_request_unit.sv
// Randomised and directed bench for traffic_request_unit against a behavioural model.
// Latency: outputs sampled 1 time unit after each rising edge.
// No backpressure: inputs are driven between edges only.
module tb_traffic_request_unit;

    localparam int DEB  = 3;
    localparam int MAXW = 15;
`ifdef TRC_CONFLICT_EN
    localparam bit CONF_EN = 1'b1;
`else
    localparam bit CONF_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  sensor = '0;
    logic [11:0] lights = {3'b100, 3'b100, 3'b100, 3'b100};
    logic        ns_traffic, ew_traffic, sw_ne_traffic, wn_es_traffic;
    logic [3:0]  starve;
    logic        conflict;

    int checks = 0;
    int failures = 0;

    // Behavioural model: consecutive-high streak, pending flag, served flag, wait age
    int m_streak [4];
    bit m_pend   [4];
    bit m_served [4];
    int m_age    [4];
    bit m_conf;

    traffic_request_unit #(.DEBOUNCE(DEB), .MAX_WAIT(MAXW)) dut (
        .CLK(CLK), .RST(RST), .sensor(sensor),
        .ns_light(lights[2:0]), .ew_light(lights[5:3]),
        .sw_ne_light(lights[8:6]), .wn_es_light(lights[11:9]),
        .ns_traffic(ns_traffic), .ew_traffic(ew_traffic),
        .sw_ne_traffic(sw_ne_traffic), .wn_es_traffic(wn_es_traffic),
        .starve(starve), .conflict(conflict)
    );

    always #5 CLK = ~CLK;

    function automatic logic [8:0] obs();
        return {wn_es_traffic, sw_ne_traffic, ew_traffic, ns_traffic, starve, conflict};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_streak[i] = 0; m_pend[i] = 0; m_served[i] = 0; m_age[i] = 0;
        end
        m_conf = 0;
    endfunction

    function automatic void model_edge();
        int greens = 0;
        bit bad = 0;
        logic [2:0] l;
        for (int i = 0; i < 4; i++) begin
            l = lights[i*3 +: 3];
            if (l == 3'b001) greens++;
            if (l != 3'b100 && l != 3'b010 && l != 3'b001) bad = 1;
        end
        if (CONF_EN && (bad || greens > 1)) m_conf = 1;
        for (int i = 0; i < 4; i++) begin
            l = lights[i*3 +: 3];
            if (m_pend[i]) begin
                if (l == 3'b001) begin
                    m_pend[i] = 0; m_served[i] = 1; m_age[i] = 0;
                end else if (m_age[i] < MAXW) begin
                    m_age[i]++;
                end
            end else if (m_served[i]) begin
                if (l != 3'b001) m_served[i] = 0;
            end else if (sensor[i]) begin
                m_streak[i]++;
                if (m_streak[i] >= DEB) begin
                    m_pend[i] = 1; m_age[i] = 0; m_streak[i] = 0;
                end
            end else begin
                m_streak[i] = 0;
            end
        end
    endfunction

    function automatic logic [8:0] model_exp();
        logic [3:0] r, s;
        r = '0; s = '0;
        for (int i = 0; i < 4; i++) begin
            r[i] = m_pend[i];
            s[i] = m_pend[i] && (m_age[i] == MAXW);
        end
        return {r, s, m_conf};
    endfunction

    task automatic step();
        @(posedge CLK);
        if (!RST) model_edge();
        #1;
    endtask

    task automatic set_light(input int i, input logic [2:0] v);
        lights[i*3 +: 3] = v;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        model_reset();
        #3;
        RST = 1'b0;
        sensor = '0;
        lights = {3'b100, 3'b100, 3'b100, 3'b100};
    endtask

    task automatic test_reset();
        logic [8:0] o;
        #1;
        checks++;
        o = obs();
        if (o !== 9'b0) begin
            failures++; $display("FAIL reset_initial: got %b expected %b", o, 9'b0);
        end
        #11 RST = 1'b0;
        model_reset();
        sensor = 4'b0001;
        for (int k = 0; k < DEB; k++) step();
        checks++;
        o = obs();
        if (o !== {4'b0001, 4'b0000, 1'b0}) begin
            failures++; $display("FAIL reset_pending_setup: got %b expected %b", o, {4'b0001, 4'b0000, 1'b0});
        end
        #2 RST = 1'b1;
        model_reset();
        #1;
        checks++;
        o = obs();
        if (o !== 9'b0) begin
            failures++; $display("FAIL reset_async: got %b expected %b", o, 9'b0);
        end
        #2 RST = 1'b0;
        sensor = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            o = obs();
            if (o !== 9'b0) begin
                failures++; $display("FAIL reset_idle cycle %0d: got %b expected %b", k, o, 9'b0);
            end
        end
    endtask

    task automatic test_debounce();
        sensor = 4'b0010;
        step(); step();
        sensor = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (ew_traffic !== 1'b0) begin
                failures++; $display("FAIL debounce_reject cycle %0d: got %b expected 0", k, ew_traffic);
            end
        end
        sensor = 4'b0010;
        for (int k = 1; k <= DEB; k++) begin
            step();
            checks++;
            if (ew_traffic !== (k == DEB)) begin
                failures++; $display("FAIL debounce_accept edge %0d: got %b expected %b", k, ew_traffic, k == DEB);
            end
        end
        sensor = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (ew_traffic !== 1'b1) begin
                failures++; $display("FAIL debounce_hold cycle %0d: got %b expected 1", k, ew_traffic);
            end
        end
        set_light(1, 3'b001);
        step();
        checks++;
        if (ew_traffic !== 1'b0) begin
            failures++; $display("FAIL debounce_clear: got %b expected 0", ew_traffic);
        end
        set_light(1, 3'b100);
        step();
    endtask

    task automatic test_serve();
        sensor = 4'b0001;
        for (int k = 0; k < DEB; k++) step();
        checks++;
        if (ns_traffic !== 1'b1) begin
            failures++; $display("FAIL serve_pending: got %b expected 1", ns_traffic);
        end
        set_light(0, 3'b001);
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (ns_traffic !== 1'b0) begin
                failures++; $display("FAIL serve_clear cycle %0d: got %b expected 0", k, ns_traffic);
            end
        end
        set_light(0, 3'b010);
        step();
        for (int k = 1; k <= DEB; k++) begin
            step();
            checks++;
            if (ns_traffic !== (k == DEB)) begin
                failures++; $display("FAIL serve_rearm edge %0d: got %b expected %b", k, ns_traffic, k == DEB);
            end
        end
        sensor = 4'b0000;
        set_light(0, 3'b001);
        step();
        set_light(0, 3'b100);
        step();
    endtask

    task automatic test_starve();
        logic [3:0] e;
        sensor = 4'b0100;
        for (int k = 0; k < DEB; k++) step();
        sensor = 4'b0000;
        for (int k = 1; k <= MAXW + 3; k++) begin
            step();
            e = (k >= MAXW) ? 4'b0100 : 4'b0000;
            checks++;
            if (starve !== e || sw_ne_traffic !== 1'b1) begin
                failures++; $display("FAIL starve edge %0d: got starve=%b req=%b expected starve=%b req=1", k, starve, sw_ne_traffic, e);
            end
        end
        set_light(2, 3'b001);
        step();
        checks++;
        if (starve !== 4'b0000 || sw_ne_traffic !== 1'b0) begin
            failures++; $display("FAIL starve_clear: got starve=%b req=%b expected starve=0000 req=0", starve, sw_ne_traffic);
        end
        set_light(2, 3'b100);
        step();
    endtask

    task automatic test_independence();
        logic [3:0] r;
        sensor = 4'b1111;
        for (int k = 1; k <= DEB; k++) begin
            step();
            r = {wn_es_traffic, sw_ne_traffic, ew_traffic, ns_traffic};
            checks++;
            if (r !== ((k == DEB) ? 4'b1111 : 4'b0000)) begin
                failures++; $display("FAIL indep_rise edge %0d: got %b expected %b", k, r, (k == DEB) ? 4'b1111 : 4'b0000);
            end
        end
        sensor = 4'b0000;
        set_light(1, 3'b001);
        step();
        r = {wn_es_traffic, sw_ne_traffic, ew_traffic, ns_traffic};
        checks++;
        if (r !== 4'b1101) begin
            failures++; $display("FAIL indep_ew_clear: got %b expected %b", r, 4'b1101);
        end
        do_reset();
    endtask

    task automatic test_conflict();
        set_light(0, 3'b001);
        set_light(1, 3'b001);
        step();
        set_light(0, 3'b100);
        set_light(1, 3'b100);
        checks++;
        if (conflict !== CONF_EN) begin
            failures++; $display("FAIL conflict_double_green: got %b expected %b", conflict, CONF_EN);
        end
        step(); step();
        checks++;
        if (conflict !== CONF_EN) begin
            failures++; $display("FAIL conflict_sticky: got %b expected %b", conflict, CONF_EN);
        end
        do_reset();
        #1;
        checks++;
        if (conflict !== 1'b0) begin
            failures++; $display("FAIL conflict_reset: got %b expected 0", conflict);
        end
        set_light(3, 3'b011);
        step();
        set_light(3, 3'b100);
        checks++;
        if (conflict !== CONF_EN) begin
            failures++; $display("FAIL conflict_not_onehot: got %b expected %b", conflict, CONF_EN);
        end
        step();
        do_reset();
    endtask

    task automatic test_random();
        logic [8:0] o, e;
        int r;
        for (int round = 0; round < 2; round++) begin
            for (int c = 0; c < 250; c++) begin
                for (int i = 0; i < 4; i++) begin
                    sensor[i] = ($urandom_range(0, 3) != 0);
                    r = $urandom_range(0, 63);
                    if (r == 0) set_light(i, 3'($urandom_range(0, 7)));
                    else if (r < 8) set_light(i, 3'b001);
                    else if (r < 16) set_light(i, 3'b010);
                    else set_light(i, 3'b100);
                end
                step();
                o = obs();
                e = model_exp();
                checks++;
                if (o !== e) begin
                    failures++; $display("FAIL random r%0d c%0d: got %b expected %b", round, c, o, e);
                end
            end
            do_reset();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_debounce();
        test_serve();
        test_starve();
        test_independence();
        test_conflict();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
